// File: rtl/banked_scalar_reg_file_if.sv
// ============================================================================
// banked_scalar_reg_file_if: shared types and the port bundle of the scalar register file
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package banked_scalar_reg_file_pkg;
  localparam int IMEM_ADDR_WIDTH = 16;

  typedef logic [IMEM_ADDR_WIDTH-1:0] instruction_memory_address_t;

  typedef enum logic [2:0] {
    ALU_OUT          = 3'd0,
    LSU_OUT          = 3'd1,
    IMMEDIATE        = 3'd2,
    PC_PLUS_1        = 3'd3,
    VECTOR_TO_SCALAR = 3'd4
  } reg_input_mux_t;
endpackage

interface banked_scalar_reg_file_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32
);
  import banked_scalar_reg_file_pkg::*;

  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int AW = $clog2(NUM_REGS);

  // read port and issue-stage hazard query
  logic                            rd_req;
  logic [WW-1:0]                   rd_warp;
  logic [AW-1:0]                   rs1_addr;
  logic [AW-1:0]                   rs2_addr;
  logic [DATA_WIDTH-1:0]           rs1;
  logic [DATA_WIDTH-1:0]           rs2;
  logic                            rd_valid;
  logic [AW-1:0]                   hz_rd_addr;
  logic                            hazard;

  // execute writeback
  logic                            wb_en;
  logic [WW-1:0]                   wb_warp;
  logic [AW-1:0]                   wb_addr;
  reg_input_mux_t                  wb_mux;
  logic [DATA_WIDTH-1:0]           alu_out;
  logic [DATA_WIDTH-1:0]           lsu_out;
  logic [DATA_WIDTH-1:0]           immediate;
  logic [DATA_WIDTH-1:0]           vector_to_scalar_data;
  instruction_memory_address_t     pc;

  // scoreboard set and late load return
  logic                            sb_set;
  logic [WW-1:0]                   sb_warp;
  logic [AW-1:0]                   sb_addr;
  logic                            ld_en;
  logic [WW-1:0]                   ld_warp;
  logic [AW-1:0]                   ld_addr;
  logic [DATA_WIDTH-1:0]           ld_data;

  logic [NUM_WARPS*DATA_WIDTH-1:0] exec_masks;

  modport master (
    output rd_req, rd_warp, rs1_addr, rs2_addr, hz_rd_addr,
    output wb_en, wb_warp, wb_addr, wb_mux, alu_out, lsu_out, immediate,
    output vector_to_scalar_data, pc,
    output sb_set, sb_warp, sb_addr, ld_en, ld_warp, ld_addr, ld_data,
    input  rs1, rs2, rd_valid, hazard, exec_masks
  );

  modport slave (
    input  rd_req, rd_warp, rs1_addr, rs2_addr, hz_rd_addr,
    input  wb_en, wb_warp, wb_addr, wb_mux, alu_out, lsu_out, immediate,
    input  vector_to_scalar_data, pc,
    input  sb_set, sb_warp, sb_addr, ld_en, ld_warp, ld_addr, ld_data,
    output rs1, rs2, rd_valid, hazard, exec_masks
  );
endinterface

`default_nettype wire

// File: rtl/banked_scalar_reg_file.sv
// ============================================================================
// banked_scalar_reg_file: per-warp scalar registers, bypassed read port, load scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module banked_scalar_reg_file
  import banked_scalar_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_WARPS  = 4,
  parameter int NUM_REGS   = 32
) (
  input wire logic                 clk,
  input wire logic                 reset,
  banked_scalar_reg_file_if.slave  bus
);

  localparam int AW       = $clog2(NUM_REGS);
  localparam int MASK_REG = NUM_REGS - 1;
  localparam logic [DATA_WIDTH-1:0] C_ONES = '1;

  logic [DATA_WIDTH-1:0]             r_regs [NUM_WARPS][NUM_REGS];
  logic [NUM_WARPS-1:0][NUM_REGS-1:0] r_pending;
  logic [DATA_WIDTH-1:0]             r_rs1;
  logic [DATA_WIDTH-1:0]             r_rs2;
  logic                              r_rd_valid;

  instruction_memory_address_t       w_pc_plus_1;
  logic [DATA_WIDTH-1:0]             w_wb_data;
  logic                              w_wb_src_ok;
  logic                              w_wb_write;
  logic                              w_ld_write;
  logic                              w_sb_set;

  // pc + 1 wraps within the pc width before being widened
  assign w_pc_plus_1 = bus.pc + 1'b1;

  always_comb begin
    w_wb_data   = '0;
    w_wb_src_ok = 1'b1;
    case (bus.wb_mux)
      ALU_OUT:          w_wb_data = bus.alu_out;
      LSU_OUT:          w_wb_data = bus.lsu_out;
      IMMEDIATE:        w_wb_data = bus.immediate;
      PC_PLUS_1:        w_wb_data = DATA_WIDTH'(w_pc_plus_1);
      VECTOR_TO_SCALAR: w_wb_data = bus.vector_to_scalar_data;
      default:          w_wb_src_ok = 1'b0;
    endcase
  end

  assign w_wb_write = bus.wb_en && w_wb_src_ok && (bus.wb_addr != '0);
  assign w_ld_write = bus.ld_en && (bus.ld_addr != '0);
  assign w_sb_set   = bus.sb_set && (bus.sb_addr != '0);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && bus.wb_en && !w_wb_src_ok)
      $error("banked_scalar_reg_file: illegal wb_mux value %0d", bus.wb_mux);
  end
`endif

  // Operand value as it will stand after this cycle's writes (wb over ld)
  function automatic logic [DATA_WIDTH-1:0] f_read(input logic [AW-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = r_regs[bus.rd_warp][a];
    if (w_wb_write && (bus.wb_warp == bus.rd_warp) && (bus.wb_addr == a))
      v = w_wb_data;
    else if (w_ld_write && (bus.ld_warp == bus.rd_warp) && (bus.ld_addr == a))
      v = bus.ld_data;
    if (a == '0)
      v = '0;
    return v;
  endfunction

  // Later non-blocking assignment wins, giving wb priority over ld
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          r_regs[w][r] <= ((r == 1) || (r == MASK_REG)) ? C_ONES : '0;
        end
      end
    end else begin
      if (w_ld_write)
        r_regs[bus.ld_warp][bus.ld_addr] <= bus.ld_data;
      if (w_wb_write)
        r_regs[bus.wb_warp][bus.wb_addr] <= w_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      if (bus.ld_en)
        r_pending[bus.ld_warp][bus.ld_addr] <= 1'b0;
      if (w_sb_set)
        r_pending[bus.sb_warp][bus.sb_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        r_rs1 <= f_read(bus.rs1_addr);
        r_rs2 <= f_read(bus.rs2_addr);
      end
    end
  end

  assign bus.rs1      = r_rs1;
  assign bus.rs2      = r_rs2;
  assign bus.rd_valid = r_rd_valid;
  assign bus.hazard   = r_pending[bus.rd_warp][bus.rs1_addr]
                      | r_pending[bus.rd_warp][bus.rs2_addr]
                      | r_pending[bus.rd_warp][bus.hz_rd_addr];

  for (genvar gw = 0; gw < NUM_WARPS; gw++) begin : g_mask
    assign bus.exec_masks[gw*DATA_WIDTH +: DATA_WIDTH] = r_regs[gw][MASK_REG];
  end

endmodule

`default_nettype wire

// File: tb/tb_banked_scalar_reg_file.sv
// ============================================================================
// tb_banked_scalar_reg_file: scoreboard bench with directed and random traffic
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_banked_scalar_reg_file;
  import banked_scalar_reg_file_pkg::*;

  localparam int DW = 32;
  localparam int NW = 4;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  banked_scalar_reg_file_if #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR)) bus ();

  banked_scalar_reg_file #(.DATA_WIDTH(DW), .NUM_WARPS(NW), .NUM_REGS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } rd_exp_t;

  rd_exp_t     q[$];
  logic [31:0] m_reg [NW][NR];
  bit          m_pend [NW][NR];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < NW; w++)
      for (int a = 0; a < NR; a++) begin
        m_reg[w][a]  = (a == 1 || a == NR - 1) ? 32'hFFFF_FFFF : 32'h0;
        m_pend[w][a] = 1'b0;
      end
  endfunction

  function automatic logic [31:0] wb_val();
    case (bus.wb_mux)
      ALU_OUT:          return bus.alu_out;
      LSU_OUT:          return bus.lsu_out;
      IMMEDIATE:        return bus.immediate;
      PC_PLUS_1:        return 32'((int'(bus.pc) + 1) % 65536);
      default:          return bus.vector_to_scalar_data;
    endcase
  endfunction

  // Register contents once the writes presented this cycle have landed
  function automatic logic [31:0] model_read(input int w, input int a);
    if (a == 0) return 32'h0;
    if (bus.wb_en && int'(bus.wb_warp) == w && int'(bus.wb_addr) == a) return wb_val();
    if (bus.ld_en && int'(bus.ld_warp) == w && int'(bus.ld_addr) == a) return bus.ld_data;
    return m_reg[w][a];
  endfunction

  function automatic bit model_pend_next(input int w, input int a);
    if (a == 0) return 1'b0;
    if (bus.sb_set && int'(bus.sb_warp) == w && int'(bus.sb_addr) == a) return 1'b1;
    if (bus.ld_en && int'(bus.ld_warp) == w && int'(bus.ld_addr) == a) return 1'b0;
    return m_pend[w][a];
  endfunction

  task automatic idle();
    bus.rd_req = 0; bus.rd_warp = 0; bus.rs1_addr = 0; bus.rs2_addr = 0; bus.hz_rd_addr = 0;
    bus.wb_en = 0; bus.wb_warp = 0; bus.wb_addr = 0; bus.wb_mux = ALU_OUT;
    bus.alu_out = 0; bus.lsu_out = 0; bus.immediate = 0; bus.vector_to_scalar_data = 0; bus.pc = 0;
    bus.sb_set = 0; bus.sb_warp = 0; bus.sb_addr = 0;
    bus.ld_en = 0; bus.ld_warp = 0; bus.ld_addr = 0; bus.ld_data = 0;
  endtask

  // One clock: inputs are already driven (after a negedge)
  task automatic cycle();
    logic [31:0] nxt [NW][NR];
    bit          pnxt [NW][NR];
    logic        exp_h;
    logic        was_reset;
    int          rw;
    was_reset = reset;
    rw = int'(bus.rd_warp);
    #1;
    exp_h = m_pend[rw][bus.rs1_addr] | m_pend[rw][bus.rs2_addr] | m_pend[rw][bus.hz_rd_addr];
    check("hazard", 32'(bus.hazard), 32'(exp_h));
    if (!was_reset) begin
      if (bus.rd_req)
        q.push_back('{model_read(rw, int'(bus.rs1_addr)), model_read(rw, int'(bus.rs2_addr))});
      for (int w = 0; w < NW; w++)
        for (int a = 0; a < NR; a++) begin
          nxt[w][a]  = model_read(w, a);
          pnxt[w][a] = model_pend_next(w, a);
        end
    end
    @(posedge clk);
    if (was_reset) begin
      model_reset();
    end else begin
      for (int w = 0; w < NW; w++)
        for (int a = 0; a < NR; a++) begin
          m_reg[w][a]  = nxt[w][a];
          m_pend[w][a] = pnxt[w][a];
        end
    end
    @(negedge clk);
    if (was_reset) check("rd_valid_after_reset", 32'(bus.rd_valid), 32'h0);
    for (int w = 0; w < NW; w++)
      check("exec_mask", bus.exec_masks[w*DW +: DW], m_reg[w][NR-1]);
  endtask

  task automatic rd(input int w, input int a, input int b);
    bus.rd_req = 1; bus.rd_warp = 2'(w); bus.rs1_addr = 5'(a); bus.rs2_addr = 5'(b);
  endtask

  function automatic logic [4:0] pick();
    int a;
    a = $urandom_range(0, 9);
    return (a == 9) ? 5'd31 : 5'(a);
  endfunction

  // Monitor: pops one expectation per valid read result
  initial begin
    rd_exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.rd_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_valid_unexpected: got rd_valid=1 expected no pending read");
        end else begin
          e = q.pop_front();
          check("rs1", bus.rs1, e.a);
          check("rs2", bus.rs2, e.b);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 0;

    // reset state through the read port
    rd(0, 0, 1); cycle();
    rd(0, 31, 1); cycle();

    // same-cycle writeback bypass, and warp isolation
    idle(); rd(2, 5, 5);
    bus.wb_en = 1; bus.wb_warp = 2; bus.wb_addr = 5; bus.wb_mux = IMMEDIATE; bus.immediate = 32'h1234;
    cycle();
    idle(); rd(1, 5, 0); cycle();

    // load-use scoreboard round trip
    idle(); bus.sb_set = 1; bus.sb_warp = 1; bus.sb_addr = 7; cycle();
    idle(); rd(1, 0, 7); cycle();
    idle(); rd(1, 0, 7); cycle();
    idle(); bus.ld_en = 1; bus.ld_warp = 1; bus.ld_addr = 7; bus.ld_data = 32'hCAFE; cycle();
    idle(); rd(1, 7, 7); cycle();

    // set and clear together: set wins, data still lands
    idle(); bus.sb_set = 1; bus.sb_warp = 3; bus.sb_addr = 9;
    bus.ld_en = 1; bus.ld_warp = 3; bus.ld_addr = 9; bus.ld_data = 32'h99; cycle();
    idle(); rd(3, 9, 0); bus.hz_rd_addr = 9; cycle();

    // wb beats ld; reg 0 stays zero; pc+1 wraps
    idle(); bus.wb_en = 1; bus.wb_warp = 0; bus.wb_addr = 4; bus.wb_mux = ALU_OUT; bus.alu_out = 1;
    bus.ld_en = 1; bus.ld_warp = 0; bus.ld_addr = 4; bus.ld_data = 2; cycle();
    idle(); rd(0, 4, 0);
    bus.wb_en = 1; bus.wb_warp = 0; bus.wb_addr = 0; bus.wb_mux = ALU_OUT; bus.alu_out = 32'hDEAD; cycle();
    idle(); rd(0, 6, 0);
    bus.wb_en = 1; bus.wb_warp = 0; bus.wb_addr = 6; bus.wb_mux = PC_PLUS_1; bus.pc = 16'hFFFF; cycle();
    idle(); bus.wb_en = 1; bus.wb_warp = 0; bus.wb_addr = 8; bus.wb_mux = PC_PLUS_1; bus.pc = 16'h0005; cycle();
    idle(); rd(0, 6, 8); cycle();

    // mask register of warp 1
    idle(); bus.wb_en = 1; bus.wb_warp = 1; bus.wb_addr = 31; bus.wb_mux = ALU_OUT; bus.alu_out = 32'hF0;
    cycle();
    idle(); rd(1, 31, 0); cycle();

    // randomized traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      idle();
      bus.rd_req = 1'($urandom_range(0, 1));
      bus.rd_warp = 2'($urandom_range(0, 3));
      bus.rs1_addr = pick(); bus.rs2_addr = pick(); bus.hz_rd_addr = pick();
      bus.wb_en = ($urandom_range(0, 2) == 0);
      bus.wb_warp = 2'($urandom_range(0, 3)); bus.wb_addr = pick();
      bus.wb_mux = reg_input_mux_t'(3'($urandom_range(0, 4)));
      bus.alu_out = $urandom; bus.lsu_out = $urandom; bus.immediate = $urandom;
      bus.vector_to_scalar_data = $urandom;
      bus.pc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.sb_set = ($urandom_range(0, 3) == 0);
      bus.sb_warp = 2'($urandom_range(0, 3)); bus.sb_addr = pick();
      bus.ld_en = ($urandom_range(0, 3) == 0);
      bus.ld_warp = 2'($urandom_range(0, 3)); bus.ld_addr = pick(); bus.ld_data = $urandom;
      reset = (i == 200);
      cycle();
    end
    reset = 0;

    idle(); cycle();
    cycle();
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
